// File: rtl/minmax_tracker_pkg.sv
// Shared constants and types for the min/max/equal-run statistics tracker.
package minmax_tracker_pkg;

    localparam int DW = 4;

    localparam logic [DW-1:0] MAX_INIT  = 4'h0;
    localparam logic [DW-1:0] MIN_INIT  = 4'hF;
    localparam logic [DW-1:0] LAST_INIT = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample stream and result bundle between a producer and the tracker.
interface minmax_tracker_if #(
    parameter int CW = 4
);
    import minmax_tracker_pkg::*;

    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_val;
    logic [DW-1:0] min_val;
    logic [CW-1:0] eq_count;
    logic [CW-1:0] sample_count;

    modport master (
        output start, in_valid, in_data,
        input  busy, done, max_val, min_val, eq_count, sample_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output busy, done, max_val, min_val, eq_count, sample_count
    );

endinterface

// File: rtl/minmax_tracker_cmp4_unit.sv
// 4-bit unsigned magnitude compare; exactly one of eq/gt/lt is high.
module cmp4_unit
    import minmax_tracker_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          eq,
    output logic          gt,
    output logic          lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Windowed running max/min and repeat-count tracker fed by a sample stream;
// result is held with done until the next start or reset.
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter  int N_SAMPLES = 8,
    localparam int CW        = $clog2(N_SAMPLES + 1)
)
(
    input  logic            clk,
    input  logic            reset,
    minmax_tracker_if.slave bus
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES);

    state_t        state_r;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] max_r;
    logic [DW-1:0] min_r;
    logic [DW-1:0] last_r;
    logic [CW-1:0] eq_r;
    logic [CW-1:0] cnt_r;

    logic max_eq_s, max_gt_s, max_lt_s;
    logic min_eq_s, min_gt_s, min_lt_s;
    logic lst_eq_s, lst_gt_s, lst_lt_s;

    logic          max_upd_s;
    logic          min_upd_s;
    logic          rep_s;
    logic          first_s;
    logic [CW-1:0] cnt_next_s;
    logic          last_sample_s;

    cmp4_unit u_cmp_max (
        .a  (bus.in_data),
        .b  (max_r),
        .eq (max_eq_s),
        .gt (max_gt_s),
        .lt (max_lt_s)
    );

    cmp4_unit u_cmp_min (
        .a  (bus.in_data),
        .b  (min_r),
        .eq (min_eq_s),
        .gt (min_gt_s),
        .lt (min_lt_s)
    );

    cmp4_unit u_cmp_last (
        .a  (bus.in_data),
        .b  (last_r),
        .eq (lst_eq_s),
        .gt (lst_gt_s),
        .lt (lst_lt_s)
    );

    // A compare result that is not one-hot is treated as "no update".
    assign max_upd_s     = max_gt_s & ~max_eq_s & ~max_lt_s;
    assign min_upd_s     = min_lt_s & ~min_eq_s & ~min_gt_s;
    assign rep_s         = lst_eq_s & ~lst_gt_s & ~lst_lt_s;
    assign first_s       = (cnt_r == CNT_ZERO);
    assign cnt_next_s    = cnt_r + CNT_ONE;
    assign last_sample_s = (cnt_next_s == CNT_LAST);

    // Window control and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            max_r   <= MAX_INIT;
            min_r   <= MIN_INIT;
            last_r  <= LAST_INIT;
            eq_r    <= CNT_ZERO;
            cnt_r   <= CNT_ZERO;
        end else if (bus.start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            max_r   <= MAX_INIT;
            min_r   <= MIN_INIT;
            last_r  <= LAST_INIT;
            eq_r    <= CNT_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                RUN: begin
                    if (bus.in_valid) begin
                        cnt_r  <= cnt_next_s;
                        last_r <= bus.in_data;
                        if (first_s) begin
                            max_r <= bus.in_data;
                            min_r <= bus.in_data;
                        end else begin
                            if (max_upd_s) begin
                                max_r <= bus.in_data;
                            end else begin
                                max_r <= max_r;
                            end
                            if (min_upd_s) begin
                                min_r <= bus.in_data;
                            end else begin
                                min_r <= min_r;
                            end
                        end
                        if (rep_s && !first_s) begin
                            eq_r <= eq_r + CNT_ONE;
                        end else begin
                            eq_r <= eq_r;
                        end
                        if (last_sample_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.max_val      = max_r;
    assign bus.min_val      = min_r;
    assign bus.eq_count     = eq_r;
    assign bus.sample_count = cnt_r;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: vector table plus gap-stream and
// single-sample-window sequences.
module tb_minmax_tracker;

    logic clk;
    logic reset;

    minmax_tracker_if #(.CW(4)) bus8 ();
    minmax_tracker_if #(.CW(1)) bus1 ();

    minmax_tracker #(.N_SAMPLES(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    minmax_tracker #(.N_SAMPLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       st;
        logic       vl;
        logic [3:0] d;
        logic       busy;
        logic       done;
        logic [3:0] mx;
        logic [3:0] mn;
        logic [7:0] eq;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] gs [8] = '{4'h5, 4'h3, 4'h3, 4'h9, 4'h9, 4'h9, 4'h0, 4'h7};
    logic [3:0] gmx[8] = '{4'h5, 4'h5, 4'h5, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [3:0] gmn[8] = '{4'h5, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0};
    logic [7:0] geq[8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    task automatic add(input logic rst, input logic st, input logic vl, input logic [3:0] d,
                       input logic b, input logic dn, input logic [3:0] mx, input logic [3:0] mn,
                       input int eq, input int cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.vl = vl; v.d = d;
        v.busy = b; v.done = dn; v.mx = mx; v.mn = mn;
        v.eq = 8'(eq); v.cnt = 8'(cnt);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check8(input string tag, input int idx, input logic b, input logic dn,
                          input logic [3:0] mx, input logic [3:0] mn, input logic [7:0] eq,
                          input logic [7:0] cnt);
        chk({tag, ".busy"}, idx, {7'd0, bus8.busy}, {7'd0, b});
        chk({tag, ".done"}, idx, {7'd0, bus8.done}, {7'd0, dn});
        chk({tag, ".max"},  idx, {4'd0, bus8.max_val}, {4'd0, mx});
        chk({tag, ".min"},  idx, {4'd0, bus8.min_val}, {4'd0, mn});
        chk({tag, ".eq"},   idx, {4'd0, bus8.eq_count}, eq);
        chk({tag, ".cnt"},  idx, {4'd0, bus8.sample_count}, cnt);
    endtask

    task automatic check1(input int idx, input logic b, input logic dn, input logic [3:0] mx,
                          input logic [3:0] mn, input logic eq, input logic cnt);
        chk("n1.busy", idx, {7'd0, bus1.busy}, {7'd0, b});
        chk("n1.done", idx, {7'd0, bus1.done}, {7'd0, dn});
        chk("n1.max",  idx, {4'd0, bus1.max_val}, {4'd0, mx});
        chk("n1.min",  idx, {4'd0, bus1.min_val}, {4'd0, mn});
        chk("n1.eq",   idx, {7'd0, bus1.eq_count}, {7'd0, eq});
        chk("n1.cnt",  idx, {7'd0, bus1.sample_count}, {7'd0, cnt});
    endtask

    task automatic drive8(input logic st, input logic vl, input logic [3:0] d);
        @(negedge clk);
        bus8.start    = st;
        bus8.in_valid = vl;
        bus8.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic st, input logic vl, input logic [3:0] d);
        @(negedge clk);
        bus1.start    = st;
        bus1.in_valid = vl;
        bus1.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus8.start = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = 4'h0;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = 4'h0;

        // reset, idle, main stream, done hold
        add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 4'h5, 4'h5, 0, 1);
        add(1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 4'h3, 0, 2);
        add(1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 4'h3, 1, 3);
        add(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 4'h9, 4'h3, 1, 4);
        add(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 4'h9, 4'h3, 2, 5);
        add(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 4'h9, 4'h3, 3, 6);
        add(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h9, 4'h0, 3, 7);
        add(1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 4'h9, 4'h0, 3, 8);
        add(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 4'h9, 4'h0, 3, 8);
        add(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h9, 4'h0, 3, 8);
        add(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h9, 4'h0, 3, 8);
        // restart from DONE, then start colliding with a valid sample
        add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 4'h1, 4'h1, 0, 1);
        add(1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'h1, 0, 2);
        add(1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'h1, 1, 3);
        add(1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 4'h4, 4'h1, 1, 4);
        add(1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 4'hF, 0, 0);
        // five samples then reset (with start, reset wins)
        add(1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 4'h6, 4'h6, 0, 1);
        add(1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 4'h6, 4'h6, 1, 2);
        add(1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 4'h7, 4'h6, 1, 3);
        add(1'b0, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 4'h8, 4'h6, 1, 4);
        add(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 4'h9, 4'h6, 1, 5);
        add(1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 4'hF, 0, 0);
        add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 1'b0, 1'b1, 4'hA, (i < 7), (i == 7), 4'hA, 4'hA, i, i + 1);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset         = tbl[i].rst;
            bus8.start    = tbl[i].st;
            bus8.in_valid = tbl[i].vl;
            bus8.in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            check8("tbl", i, tbl[i].busy, tbl[i].done, tbl[i].mx, tbl[i].mn, tbl[i].eq, tbl[i].cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        bus8.start = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = 4'h0;

        // same stream with idle gaps; data on gap cycles must be ignored
        drive8(1'b1, 1'b0, 4'h0);
        check8("gap.start", 0, 1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            drive8(1'b0, 1'b1, gs[k]);
            check8("gap.acc", k, (k < 7), (k == 7), gmx[k], gmn[k], geq[k], 8'(k + 1));
            for (int g = 0; g < (k % 3) + 1; g++) begin
                drive8(1'b0, 1'b0, 4'hF);
                check8("gap.idle", k, (k < 7), (k == 7), gmx[k], gmn[k], geq[k], 8'(k + 1));
            end
        end

        // single-sample window
        drive1(1'b1, 1'b0, 4'h0);
        check1(0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        drive1(1'b0, 1'b1, 4'h7);
        check1(1, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0, 1'b1);
        drive1(1'b0, 1'b1, 4'h3);
        check1(2, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0, 1'b1);
        drive1(1'b1, 1'b0, 4'h0);
        check1(3, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        drive1(1'b0, 1'b1, 4'h0);
        check1(4, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        bus1.start = 1'b0; bus1.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Sequential stage directly downstream of the team's 4-bit magnitude comparator.
- Consumes a stream of 4-bit samples over a fixed-length window.
- Per sample, uses equal/greater/less results to track the running maximum, the running minimum, and the count of samples equal to the previous accepted sample.
- Reports a held result with a done flag at window end.

Parameters:
- N_SAMPLES, 8, window length in accepted samples; legal range 1..255.
- CW, $clog2(N_SAMPLES+1), width of the sample and equal counters (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; clears statistics and opens a new window.
- in_valid  input  1  qualifies in_data this cycle.
- in_data  input  4  unsigned sample.
- busy  output  1  high while the window is open (state RUN).
- done  output  1  high while the result is held (state DONE).
- max_val  output  4  running/final maximum.
- min_val  output  4  running/final minimum.
- eq_count  output  CW  number of accepted samples equal to the immediately preceding accepted sample.
- sample_count  output  CW  accepted samples in the current window.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: state IDLE, busy=0, done=0, max_val=4'h0, min_val=4'hF, eq_count=0, sample_count=0, last-sample register=4'h0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_valid is ignored.
  - start=1: clear statistics to reset values, go to RUN next cycle.
- RUN (busy=1):
  - On each cycle with in_valid=1 and start=0, the sample is accepted and sample_count increments.
  - Two comparisons run in parallel:
    - in_data vs max_val: if gt, max_val<=in_data.
    - in_data vs min_val: if lt, min_val<=in_data.
  - First sample (sample_count==0) loads max_val and min_val unconditionally.
  - in_data vs last sample: if eq and sample_count!=0, eq_count increments.
  - Last-sample register <= in_data.
  - When the accepted sample makes sample_count==N_SAMPLES, go to DONE next cycle.
  - in_valid=0 leaves all state unchanged. No timeout.
- DONE (done=1, busy=0):
  - All statistics frozen; in_valid ignored.
  - Held indefinitely until start or reset.
- Latency: a sample accepted at edge k is reflected in max_val/min_val/eq_count/sample_count after edge k.
- done rises on the edge that accepts the Nth sample; busy falls on that same edge.
- start in any state: clear statistics, enter RUN; done drops on the next edge.
- start and in_valid in the same cycle: start wins; that sample is dropped, not counted.
- reset mid-window: immediate return to reset values; reset has priority over start.
- Comparisons are unsigned 4-bit. Counters never wrap, because sample_count saturates at N_SAMPLES by construction.
- Equal values against max/min (eq result) cause no update.
- N_SAMPLES=1: the single accepted sample gives max=min=sample, eq_count=0, DONE.

Decomposition:
- Shared package: state encoding constants IDLE/RUN/DONE, reset constants MAX_INIT=4'h0 and MIN_INIT=4'hF, sample width constant DW=4.
- One natural sub-module, cmp4_unit: 4-bit combinational compare with eq/gt/lt outputs, exactly one high.
  - Instantiated three times (vs max, vs min, vs last).
  - Behaviourally identical to the existing comparator, so it can be swapped for it.

Test Plan:
- reset held 2 cycles, then released with no start -> busy=0, done=0, max=0, min=F, counts=0; in_valid pulses in IDLE change nothing.
- N_SAMPLES=8; start, then samples 5,3,3,9,9,9,0,7 back-to-back -> after the 8th edge: max=9, min=0, eq_count=3, sample_count=8, done=1, busy=0.
- Same stream with in_valid=0 gaps of 1–3 cycles between samples -> identical final result; done asserted only after the 8th accepted sample.
- start asserted together with in_valid (data=F) mid-window after 4 samples -> sample dropped; next cycle sample_count=0, max=0, min=F, busy=1.
- reset asserted after 5 samples -> next cycle all outputs at reset values, state IDLE; a subsequent start and 8 samples of value A -> max=min=A, eq_count=7.
- In DONE, further in_valid samples (F,0) -> outputs unchanged; a start pulse -> done=0, busy=1 next cycle, counters cleared.
